// File: rtl/clk_divider_mc.sv
// clk_divider_mc: multi-channel programmable clock divider.
// Each channel divides clk by an N-bit divisor D with an N-bit high time H.
// New divisors are staged in a per-channel shadow and take effect only at a
// period boundary, so clkout never produces a runt pulse.
//
// Ports:
//   clk        system clock (rising edge)
//   n_reset    asynchronous active-low reset
//   enable     per-channel run enable; low freezes the channel
//   sync_i     one-cycle pulse; restarts every enabled running channel
//   cfg_valid  config request valid
//   cfg_ready  config accepted when cfg_valid && cfg_ready (combinational)
//   cfg_ch     target channel of the config request
//   cfg_div    new divisor D (period in clk cycles)
//   cfg_high   new high time H (clk cycles high per period)
//   clkout     divided clocks, registered
//   tick       one-cycle pulse at the start of each period, registered
module clk_divider_mc #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned N        = 8,
    parameter int unsigned DEF_DIV  = 4,
    parameter int unsigned DEF_HIGH = 2
) (
    input  logic                                clk,
    input  logic                                n_reset,
    input  logic [NCH-1:0]                      enable,
    input  logic                                sync_i,
    input  logic                                cfg_valid,
    output logic                                cfg_ready,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [N-1:0]                        cfg_div,
    input  logic [N-1:0]                        cfg_high,
    output logic [NCH-1:0]                      clkout,
    output logic [NCH-1:0]                      tick
);

    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0][N-1:0] cnt_q,   cnt_d;
    logic [NCH-1:0][N-1:0] div_q,   div_d;
    logic [NCH-1:0][N-1:0] high_q,  high_d;
    logic [NCH-1:0][N-1:0] sdiv_q,  sdiv_d;
    logic [NCH-1:0][N-1:0] shigh_q, shigh_d;
    logic [NCH-1:0]        pending_q, pending_d;
    logic [NCH-1:0]        started_q, started_d;
    logic [NCH-1:0]        clk_q,     clk_d;
    logic [NCH-1:0]        tick_q,    tick_d;

    logic [N-1:0] nd;
    logic [N-1:0] nh;
    logic         acc;
    logic         stopped;

    // Ready reflects the addressed channel's shadow; out-of-range channels
    // are always ready so their requests are silently dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            if (cfg_ch == CW'(c)) begin
                cfg_ready = !pending_q[c];
            end
        end
    end

    // Per-channel next-state: count, wrap, apply shadow, accept config.
    always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        high_d    = high_q;
        sdiv_d    = sdiv_q;
        shigh_d   = shigh_q;
        pending_d = pending_q;
        started_d = started_q;
        clk_d     = clk_q;
        tick_d    = '0;
        nd        = '0;
        nh        = '0;
        acc       = 1'b0;
        stopped   = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            acc     = cfg_valid && cfg_ready && (cfg_ch == CW'(c));
            stopped = (div_q[c] < N'(2));
            if (enable[c]) begin
                if (stopped) begin
                    cnt_d[c]     = '0;
                    clk_d[c]     = 1'b0;
                    started_d[c] = 1'b0;
                    // A stopped channel has no period to protect, so a
                    // staged or freshly offered config loads immediately.
                    if (pending_q[c] || acc) begin
                        nd = pending_q[c] ? sdiv_q[c]  : cfg_div;
                        nh = pending_q[c] ? shigh_q[c] : cfg_high;
                        div_d[c]     = nd;
                        high_d[c]    = nh;
                        pending_d[c] = 1'b0;
                        if (nd >= N'(2)) begin
                            started_d[c] = 1'b1;
                            tick_d[c]    = 1'b1;
                            clk_d[c]     = (nh != '0);
                        end
                    end
                end else if (sync_i || !started_q[c] ||
                             (cnt_q[c] == div_q[c] - N'(1))) begin
                    nd = pending_q[c] ? sdiv_q[c]  : div_q[c];
                    nh = pending_q[c] ? shigh_q[c] : high_q[c];
                    div_d[c]     = nd;
                    high_d[c]    = nh;
                    pending_d[c] = 1'b0;
                    cnt_d[c]     = '0;
                    if (nd >= N'(2)) begin
                        started_d[c] = 1'b1;
                        tick_d[c]    = 1'b1;
                        clk_d[c]     = (nh != '0);
                    end else begin
                        started_d[c] = 1'b0;
                        clk_d[c]     = 1'b0;
                    end
                end else begin
                    cnt_d[c] = cnt_q[c] + N'(1);
                    clk_d[c] = ((cnt_q[c] + N'(1)) < high_q[c]);
                end
            end
            // Stage the request unless it was consumed directly above; a
            // request on a wrap edge therefore waits for the next wrap.
            if (acc && !(enable[c] && stopped)) begin
                sdiv_d[c]    = cfg_div;
                shigh_d[c]   = cfg_high;
                pending_d[c] = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c]   <= '0;
                div_q[c]   <= N'(DEF_DIV);
                high_q[c]  <= N'(DEF_HIGH);
                sdiv_q[c]  <= '0;
                shigh_q[c] <= '0;
            end
            pending_q <= '0;
            started_q <= '0;
            clk_q     <= '0;
            tick_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            high_q    <= high_d;
            sdiv_q    <= sdiv_d;
            shigh_q   <= shigh_d;
            pending_q <= pending_d;
            started_q <= started_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
        end
    end

    assign clkout = clk_q;
    assign tick   = tick_q;

endmodule

// File: tb/tb_clk_divider_mc.sv
// Directed bench for clk_divider_mc with default parameters.
module tb_clk_divider_mc;

    logic       clk = 1'b0;
    logic       n_reset;
    logic [3:0] enable;
    logic       sync_i;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [7:0] cfg_high;
    logic [3:0] clkout;
    logic [3:0] tick;

    int checks = 0;
    int errors = 0;

    clk_divider_mc dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .enable    (enable),
        .sync_i    (sync_i),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .clkout    (clkout),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable    = '0;
        sync_i    = 1'b0;
        cfg_valid = 1'b0;
        n_reset   = 1'b0;
        #2;
        n_reset   = 1'b1;
    endtask

    task automatic set_cfg(input logic [1:0] ch, input logic [7:0] d, input logic [7:0] h);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = d;
        cfg_high  = h;
    endtask

    initial begin
        n_reset   = 1'b0;
        enable    = '0;
        sync_i    = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_high  = '0;
        #12;
        check("reset_clkout", 32'(clkout), 32'h0);
        check("reset_tick", 32'(tick), 32'h0);
        check("reset_ready", 32'(cfg_ready), 32'h1);
        n_reset = 1'b1;

        // Defaults D=4 H=2 on channel 0.
        enable = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            step();
            check("t1_clk0", 32'(clkout[0]), 32'((i % 4) < 2));
            check("t1_tick0", 32'(tick[0]), 32'((i % 4) == 0));
            check("t1_others", 32'({clkout[3:1], tick[3:1]}), 32'h0);
        end

        // Channel 1 reconfigured to D=5 H=2 while disabled.
        set_cfg(2'd1, 8'd5, 8'd2);
        check("t2_ready_pre", 32'(cfg_ready), 32'h1);
        step();
        cfg_valid = 1'b0;
        check("t2_ready_pend", 32'(cfg_ready), 32'h0);
        enable = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t2_clk1", 32'(clkout[1]), 32'((i % 5) < 2));
            check("t2_tick1", 32'(tick[1]), 32'((i % 5) == 0));
            if (i == 0) check("t2_ready_post", 32'(cfg_ready), 32'h1);
        end

        // Mid-period reconfig of channel 0 to D=6 H=3.
        do_reset();
        enable = 4'b0001;
        step();
        check("t3_c0_e1", 32'({clkout[0], tick[0]}), 32'h3);
        step();
        check("t3_c0_e2", 32'({clkout[0], tick[0]}), 32'h2);
        set_cfg(2'd0, 8'd6, 8'd3);
        check("t3_ready_pre", 32'(cfg_ready), 32'h1);
        step();
        cfg_valid = 1'b0;
        check("t3_c0_e3", 32'({clkout[0], tick[0]}), 32'h0);
        check("t3_ready_e3", 32'(cfg_ready), 32'h0);
        step();
        check("t3_c0_e4", 32'({clkout[0], tick[0]}), 32'h0);
        check("t3_ready_e4", 32'(cfg_ready), 32'h0);
        for (int i = 0; i < 12; i++) begin
            step();
            check("t3_clk0", 32'(clkout[0]), 32'((i % 6) < 3));
            check("t3_tick0", 32'(tick[0]), 32'((i % 6) == 0));
            if (i == 0) check("t3_ready_wrap", 32'(cfg_ready), 32'h1);
        end

        // Four channels D=3,4,5,6, then a sync pulse.
        do_reset();
        set_cfg(2'd0, 8'd3, 8'd1); step();
        set_cfg(2'd1, 8'd4, 8'd2); step();
        set_cfg(2'd2, 8'd5, 8'd2); step();
        set_cfg(2'd3, 8'd6, 8'd3); step();
        cfg_valid = 1'b0;
        cfg_ch    = 2'd2;
        check("t4_ready_pend", 32'(cfg_ready), 32'h0);
        enable = 4'b1111;
        for (int i = 0; i < 7; i++) step();
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        check("t4_sync_clk", 32'(clkout), 32'hF);
        check("t4_sync_tick", 32'(tick), 32'hF);
        step();
        check("t4_post_clk", 32'(clkout), 32'hE);
        check("t4_post_tick", 32'(tick), 32'h0);

        // Freeze channel 2 while high, then resume.
        enable = 4'b1011;
        for (int i = 0; i < 7; i++) begin
            step();
            check("t5_hold_clk2", 32'(clkout[2]), 32'h1);
            check("t5_hold_tick2", 32'(tick[2]), 32'h0);
        end
        enable = 4'b1111;
        step(); check("t5_res1", 32'({clkout[2], tick[2]}), 32'h0);
        step(); check("t5_res2", 32'({clkout[2], tick[2]}), 32'h0);
        step(); check("t5_res3", 32'({clkout[2], tick[2]}), 32'h0);
        step(); check("t5_res4", 32'({clkout[2], tick[2]}), 32'h3);

        // Config D=1 on channel 3 accepted on a sync wrap edge.
        set_cfg(2'd3, 8'd1, 8'd0);
        sync_i = 1'b1;
        check("t6_ready_pre", 32'(cfg_ready), 32'h1);
        step();
        sync_i    = 1'b0;
        cfg_valid = 1'b0;
        check("t6_wrap", 32'({clkout[3], tick[3]}), 32'h3);
        check("t6_ready_pend", 32'(cfg_ready), 32'h0);
        for (int i = 1; i < 6; i++) begin
            step();
            check("t6_old_clk3", 32'(clkout[3]), 32'(i < 3));
            check("t6_old_tick3", 32'(tick[3]), 32'h0);
        end
        step();
        check("t6_stop", 32'({clkout[3], tick[3]}), 32'h0);
        check("t6_ready_stop", 32'(cfg_ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_stopped", 32'({clkout[3], tick[3]}), 32'h0);
        end
        set_cfg(2'd3, 8'd2, 8'd1);
        check("t6_ready_d2", 32'(cfg_ready), 32'h1);
        step();
        cfg_valid = 1'b0;
        check("t6_ready_keep", 32'(cfg_ready), 32'h1);
        check("t6_start", 32'({clkout[3], tick[3]}), 32'h3);
        for (int i = 1; i < 4; i++) begin
            step();
            check("t6_toggle", 32'({clkout[3], tick[3]}), ((i % 2) == 0) ? 32'h3 : 32'h0);
        end

        // Asynchronous reset mid-run.
        #3;
        n_reset = 1'b0;
        #1;
        check("t7_async_clk", 32'(clkout), 32'h0);
        check("t7_async_tick", 32'(tick), 32'h0);
        #2;
        n_reset = 1'b1;
        step(); check("t7_e1", 32'({clkout, tick}), 32'hFF);
        step(); check("t7_e2", 32'({clkout, tick}), 32'hF0);
        step(); check("t7_e3", 32'({clkout, tick}), 32'h00);
        step(); check("t7_e4", 32'({clkout, tick}), 32'h00);
        step(); check("t7_e5", 32'({clkout, tick}), 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_divider_mc.md
Name: clk_divider_mc

Overview:
Multi-channel programmable clock divider. It is the parametrised successor of the single-channel divider: NCH independent channels, N-bit divisor and high-time per channel, and odd divisors with arbitrary duty. Divisor changes take effect glitch-free at the period boundary. A global sync input phase-aligns all channels. It sits in the clocking/timing subsystem and generates enables and derived clocks for peripherals from the system clk.

Parameters:
NCH, 4, number of divider channels (1..16)
N, 8, divisor/high-time width in bits
DEF_DIV, 4, active divisor loaded at reset (all channels)
DEF_HIGH, 2, active high-time loaded at reset (all channels)

Ports:
clk  input  1  system clock, all logic on rising edge
n_reset  input  1  asynchronous, active-low reset
enable  input  NCH  per-channel run enable; low = channel frozen
sync_i  input  1  one-cycle pulse; restarts all enabled channels at phase 0
cfg_valid  input  1  config request valid
cfg_ready  output  1  config accepted when cfg_valid && cfg_ready
cfg_ch  input  max(1,clog2(NCH))  target channel of config
cfg_div  input  N  new divisor D (output period = D clk cycles)
cfg_high  input  N  new high-time H (clk cycles high per period)
clkout  output  NCH  divided clocks, registered
tick  output  NCH  one-cycle pulse at start of each period, registered

Behaviour:
- Reset (async, n_reset=0): cnt=0, D_act=DEF_DIV, H_act=DEF_HIGH, shadow empty (pending=0), started=0, clkout=0, tick=0, for every channel.
- Per-channel state: cnt[N-1:0], D_act, H_act, shadow D/H, pending flag, started flag.
- Stopped channel: D_act<2. cnt held 0, clkout=0, tick=0. If pending, the shadow is loaded on the next edge with enable[c]=1, and the channel starts as below.
- Running channel, edge with enable[c]=1:
  - if started=0, or cnt==D_act-1: wrap. cnt<=0, started<=1, tick<=1; if pending, D_act/H_act<=shadow and pending<=0.
  - else cnt<=cnt+1, tick<=0.
  - clkout<=(new cnt < new H_act).
- Duty: H=0 gives constant low; H>=D gives constant high; tick still pulses every D cycles.
- enable[c]=0: cnt, clkout and started are held; tick=0; sync is ignored; a pending config waits.
- sync_i=1: every enabled running channel wraps (cnt<=0, tick<=1, pending applied, clkout<=(0<H_act)). Sync has priority over the normal count.
- Config handshake:
  - cfg_ready = !pending[cfg_ch] (combinational on cfg_ch).
  - On accept: shadow[cfg_ch]<={cfg_div,cfg_high}, pending<=1.
  - A config accepted on the same edge as that channel's wrap is applied at the following wrap, never mid-period.
  - cfg_ch>=NCH: request is accepted (cfg_ready=1) and discarded.
- Latency:
  - First clkout edge is 1 clk after the first enabled edge following reset.
  - A new config shows on clkout at the first wrap after acceptance; cfg_ready for that channel returns high the cycle after that wrap.
- Arithmetic: cnt compare is unsigned N-bit; D_act-1 is computed only when D_act>=2. There is no wrap-around past 2^N-1, since the maximum D is 2^N-1.
- Reset mid-operation: all state returns to reset values immediately; a pending config is lost.

Test Plan:
- Reset release, enable=4'b0001, defaults D=4,H=2 -> clkout[0] sequence 1,1,0,0 repeating; tick[0] every 4th cycle aligned with rising clkout; other channels stay 0.
- Config ch1 D=5,H=2, enable ch1 -> clkout[1] = 1,1,0,0,0 (period 5, odd, 40% duty); tick period 5.
- Ch0 running D=4, config D=6,H=3 accepted mid-period -> current period completes with 4 cycles, next period is 6 cycles (3 high); cfg_ready(ch0) low from the accept until the cycle after the wrap; no runt pulse.
- Channels 0..3 with D=3,4,5,6, pulse sync_i -> all clkout rise and all tick pulse on the same cycle after sync.
- Deassert enable[2] while clkout[2]=1 for 7 cycles -> clkout[2] held 1, tick[2]=0; resume continues the count from the held cnt.
- Config D=1 on ch3 -> clkout[3]=0, no tick. Then config D=2,H=1 -> cfg_ready stays high, applied on the next enabled edge, giving a toggle every clk. Assert n_reset low mid-run -> all outputs 0 asynchronously and D_act returns to 4.
